// File: rtl/mem_access_stage.sv
// MEM pipeline stage: word loads/stores over a req/ack data-memory bus with timeout,
// write-back destination resolution and the MEM/WB register.
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] alu_result,
   input  logic [31:0] rt_data,
   input  logic [1:0]  reg_dst,
   input  logic [4:0]  reg_addr_i,
   input  logic [4:0]  reg_addr_r,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic [1:0]  mem_to_reg,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic [31:0] wb_alu_result,
   output logic [31:0] wb_mem_data,
   output logic [4:0]  wb_reg_addr,
   output logic        wb_reg_write,
   output logic [1:0]  wb_mem_to_reg,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

   state_t      state, stateNext;
   logic [7:0]  cnt, cntNext;
   logic        memOp, aligned, isStore;
   logic        reqC, stallC, capture, misalignNext, busErrNext;
   logic        wbWriteNext;
   logic [4:0]  destAddr;
   logic [31:0] memDataNext;

   assign memOp   = mem_read | mem_write;
   assign aligned = (alu_result[1:0] == 2'b00);
   assign isStore = mem_write & ~mem_read;

   always_comb begin
      stateNext    = state;
      cntNext      = cnt;
      reqC         = 1'b0;
      stallC       = 1'b0;
      capture      = 1'b0;
      misalignNext = 1'b0;
      busErrNext   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (memOp && aligned) begin
               reqC = 1'b1;
               if (dmem_ack) begin
                  capture = 1'b1;
               end else begin
                  stallC    = 1'b1;
                  stateNext = S_WAIT;
                  cntNext   = 8'd1;
               end
            end else if (memOp) begin
               capture      = 1'b1;
               misalignNext = 1'b1;
            end else begin
               capture = 1'b1;
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               reqC      = 1'b1;
               capture   = 1'b1;
               stateNext = S_IDLE;
               cntNext   = '0;
            end else if (cnt == TIMEOUT_CNT) begin
               // abort: request dropped, a bubble is written back
               busErrNext = 1'b1;
               stateNext  = S_IDLE;
               cntNext    = '0;
            end else begin
               reqC    = 1'b1;
               stallC  = 1'b1;
               cntNext = cnt + 8'd1;
            end
         end
         default: begin
            stateNext = S_IDLE;
            cntNext   = '0;
         end
      endcase
   end

   always_comb begin
      destAddr = 5'd0;
      unique case (reg_dst)
         2'b00:   destAddr = reg_addr_i;
         2'b01:   destAddr = reg_addr_r;
         2'b10:   destAddr = 5'd31;
         default: destAddr = 5'd0;
      endcase
   end

   assign wbWriteNext = reg_write & ~isStore & ~misalignNext;
   assign memDataNext = (mem_read && reqC && dmem_ack) ? dmem_rdata : '0;

   // reset gates the combinational bus/stall outputs so they drop at once
   assign dmem_req   = reqC & rst;
   assign dmem_we    = reqC & rst & isStore;
   assign stall      = stallC & rst;
   assign dmem_addr  = dmem_req ? alu_result : '0;
   assign dmem_wdata = dmem_req ? rt_data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         wb_alu_result <= '0;
         wb_mem_data   <= '0;
         wb_reg_addr   <= '0;
         wb_reg_write  <= 1'b0;
         wb_mem_to_reg <= '0;
         misalign_err  <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         state        <= stateNext;
         cnt          <= cntNext;
         misalign_err <= misalignNext;
         bus_err      <= busErrNext;
         if (capture) begin
            wb_alu_result <= alu_result;
            wb_mem_data   <= memDataNext;
            wb_reg_addr   <= destAddr;
            wb_reg_write  <= wbWriteNext;
            wb_mem_to_reg <= mem_to_reg;
         end else begin
            wb_alu_result <= '0;
            wb_mem_data   <= '0;
            wb_reg_addr   <= '0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, zero-wait and multi-wait accesses,
// misalignment, timeout abort and asynchronous reset mid-transaction.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_result, rt_data, dmem_rdata;
   logic [1:0]  reg_dst, mem_to_reg;
   logic [4:0]  reg_addr_i, reg_addr_r;
   logic        mem_read, mem_write, reg_write, dmem_ack;
   logic        dmem_req, dmem_we, stall, misalign_err, bus_err;
   logic [31:0] dmem_addr, dmem_wdata, wb_alu_result, wb_mem_data;
   logic [4:0]  wb_reg_addr;
   logic        wb_reg_write;
   logic [1:0]  wb_mem_to_reg;

   int nCmp = 0;
   int nErr = 0;

   mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .alu_result(alu_result), .rt_data(rt_data), .reg_dst(reg_dst),
      .reg_addr_i(reg_addr_i), .reg_addr_r(reg_addr_r), .mem_read(mem_read), .mem_write(mem_write),
      .reg_write(reg_write), .mem_to_reg(mem_to_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
      .wb_reg_addr(wb_reg_addr), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic clearIn();
      alu_result = '0; rt_data = '0; dmem_rdata = '0; reg_dst = 2'b00; mem_to_reg = 2'b00;
      reg_addr_i = '0; reg_addr_r = '0; mem_read = 0; mem_write = 0; reg_write = 0; dmem_ack = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clearIn();
      mem_read = 1'b1; alu_result = 32'h40;
      repeat (2) @(posedge clk);
      #1;
      nCmp++; if (dmem_req !== 1'b0) begin nErr++; $display("FAIL rst_req got=%0h exp=0", dmem_req); end
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL rst_stall got=%0h exp=0", stall); end
      nCmp++; if (wb_reg_write !== 1'b0) begin nErr++; $display("FAIL rst_wbwr got=%0h exp=0", wb_reg_write); end
      nCmp++; if (wb_alu_result !== 32'h0) begin nErr++; $display("FAIL rst_wbalu got=%0h exp=0", wb_alu_result); end
      nCmp++; if (misalign_err !== 1'b0 || bus_err !== 1'b0) begin nErr++; $display("FAIL rst_errs got=%0h%0h exp=00", misalign_err, bus_err); end
      @(negedge clk);
      clearIn();
      rst = 1'b1;
   endtask

   task automatic test_alu_op();
      @(negedge clk);
      clearIn();
      alu_result = 32'h1234; reg_dst = 2'b01; reg_addr_r = 5'd5; reg_write = 1'b1; mem_to_reg = 2'b01;
      #1;
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL alu_stall got=%0h exp=0", stall); end
      nCmp++; if (dmem_req !== 1'b0) begin nErr++; $display("FAIL alu_req got=%0h exp=0", dmem_req); end
      @(posedge clk); #1;
      nCmp++; if (wb_alu_result !== 32'h1234) begin nErr++; $display("FAIL alu_wbalu got=%0h exp=1234", wb_alu_result); end
      nCmp++; if (wb_reg_addr !== 5'd5) begin nErr++; $display("FAIL alu_wbaddr got=%0d exp=5", wb_reg_addr); end
      nCmp++; if (wb_reg_write !== 1'b1) begin nErr++; $display("FAIL alu_wbwr got=%0h exp=1", wb_reg_write); end
      nCmp++; if (wb_mem_to_reg !== 2'b01) begin nErr++; $display("FAIL alu_wbm2r got=%0h exp=1", wb_mem_to_reg); end
      nCmp++; if (wb_mem_data !== 32'h0) begin nErr++; $display("FAIL alu_wbmem got=%0h exp=0", wb_mem_data); end
   endtask

   task automatic test_dest();
      logic [4:0] expAddr [4];
      expAddr[0] = 5'd9; expAddr[1] = 5'd5; expAddr[2] = 5'd31; expAddr[3] = 5'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         clearIn();
         alu_result = 32'h10 + 32'(i); reg_addr_i = 5'd9; reg_addr_r = 5'd5; reg_dst = 2'(i); reg_write = 1'b1;
         @(posedge clk); #1;
         nCmp++; if (wb_reg_addr !== expAddr[i]) begin nErr++; $display("FAIL dest%0d got=%0d exp=%0d", i, wb_reg_addr, expAddr[i]); end
      end
   endtask

   task automatic test_load_zero_wait();
      @(negedge clk);
      clearIn();
      mem_read = 1'b1; alu_result = 32'h40; reg_dst = 2'b00; reg_addr_i = 5'd7; reg_write = 1'b1;
      mem_to_reg = 2'b01; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      nCmp++; if (dmem_req !== 1'b1) begin nErr++; $display("FAIL ld0_req got=%0h exp=1", dmem_req); end
      nCmp++; if (dmem_we !== 1'b0) begin nErr++; $display("FAIL ld0_we got=%0h exp=0", dmem_we); end
      nCmp++; if (dmem_addr !== 32'h40) begin nErr++; $display("FAIL ld0_addr got=%0h exp=40", dmem_addr); end
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL ld0_stall got=%0h exp=0", stall); end
      @(posedge clk); #1;
      nCmp++; if (wb_mem_data !== 32'hDEADBEEF) begin nErr++; $display("FAIL ld0_wbmem got=%0h exp=deadbeef", wb_mem_data); end
      nCmp++; if (wb_reg_write !== 1'b1) begin nErr++; $display("FAIL ld0_wbwr got=%0h exp=1", wb_reg_write); end
      nCmp++; if (wb_reg_addr !== 5'd7) begin nErr++; $display("FAIL ld0_wbaddr got=%0d exp=7", wb_reg_addr); end
   endtask

   task automatic test_store_wait();
      @(negedge clk);
      clearIn();
      mem_write = 1'b1; alu_result = 32'h80; rt_data = 32'hA5A5A5A5; reg_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         nCmp++; if (stall !== 1'b1) begin nErr++; $display("FAIL st_stall%0d got=%0h exp=1", i, stall); end
         nCmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin nErr++; $display("FAIL st_reqwe%0d got=%0h%0h exp=11", i, dmem_req, dmem_we); end
         nCmp++; if (dmem_wdata !== 32'hA5A5A5A5) begin nErr++; $display("FAIL st_wdata%0d got=%0h exp=a5a5a5a5", i, dmem_wdata); end
         @(posedge clk); #1;
         nCmp++; if (wb_alu_result !== 32'h0 || wb_reg_write !== 1'b0) begin nErr++; $display("FAIL st_bubble%0d got=%0h/%0h exp=0/0", i, wb_alu_result, wb_reg_write); end
         @(negedge clk);
      end
      dmem_ack = 1'b1;
      #1;
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL st_ackstall got=%0h exp=0", stall); end
      nCmp++; if (dmem_req !== 1'b1) begin nErr++; $display("FAIL st_ackreq got=%0h exp=1", dmem_req); end
      @(posedge clk); #1;
      nCmp++; if (wb_alu_result !== 32'h80) begin nErr++; $display("FAIL st_wbalu got=%0h exp=80", wb_alu_result); end
      nCmp++; if (wb_reg_write !== 1'b0) begin nErr++; $display("FAIL st_wbwr got=%0h exp=0", wb_reg_write); end
      @(negedge clk);
      clearIn();
      alu_result = 32'h7; reg_dst = 2'b01; reg_addr_r = 5'd3; reg_write = 1'b1;
      #1;
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL st_idle_stall got=%0h exp=0", stall); end
      @(posedge clk); #1;
      nCmp++; if (wb_alu_result !== 32'h7 || wb_reg_write !== 1'b1) begin nErr++; $display("FAIL st_next got=%0h/%0h exp=7/1", wb_alu_result, wb_reg_write); end
   endtask

   task automatic test_misalign();
      @(negedge clk);
      clearIn();
      mem_read = 1'b1; alu_result = 32'h42; reg_write = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
      #1;
      nCmp++; if (dmem_req !== 1'b0) begin nErr++; $display("FAIL mis_req got=%0h exp=0", dmem_req); end
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL mis_stall got=%0h exp=0", stall); end
      @(posedge clk); #1;
      nCmp++; if (misalign_err !== 1'b1) begin nErr++; $display("FAIL mis_err got=%0h exp=1", misalign_err); end
      nCmp++; if (wb_reg_write !== 1'b0) begin nErr++; $display("FAIL mis_wbwr got=%0h exp=0", wb_reg_write); end
      nCmp++; if (wb_mem_data !== 32'h0) begin nErr++; $display("FAIL mis_wbmem got=%0h exp=0", wb_mem_data); end
      @(negedge clk);
      clearIn();
      @(posedge clk); #1;
      nCmp++; if (misalign_err !== 1'b0) begin nErr++; $display("FAIL mis_pulse got=%0h exp=0", misalign_err); end
   endtask

   task automatic test_timeout();
      @(negedge clk);
      clearIn();
      mem_read = 1'b1; alu_result = 32'h100; reg_write = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         nCmp++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin nErr++; $display("FAIL to_wait%0d got=%0h%0h exp=11", i, stall, dmem_req); end
         @(posedge clk); #1;
         nCmp++; if (bus_err !== 1'b0) begin nErr++; $display("FAIL to_early%0d got=%0h exp=0", i, bus_err); end
         @(negedge clk);
      end
      #1;
      nCmp++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin nErr++; $display("FAIL to_abort got=%0h%0h exp=00", stall, dmem_req); end
      @(posedge clk); #1;
      nCmp++; if (bus_err !== 1'b1) begin nErr++; $display("FAIL to_buserr got=%0h exp=1", bus_err); end
      nCmp++; if (wb_reg_write !== 1'b0 || wb_alu_result !== 32'h0) begin nErr++; $display("FAIL to_bubble got=%0h/%0h exp=0/0", wb_reg_write, wb_alu_result); end
      @(negedge clk);
      clearIn();
      alu_result = 32'h55; reg_write = 1'b1;
      #1;
      nCmp++; if (stall !== 1'b0) begin nErr++; $display("FAIL to_nextstall got=%0h exp=0", stall); end
      @(posedge clk); #1;
      nCmp++; if (bus_err !== 1'b0) begin nErr++; $display("FAIL to_pulse got=%0h exp=0", bus_err); end
      nCmp++; if (wb_alu_result !== 32'h55 || wb_reg_write !== 1'b1) begin nErr++; $display("FAIL to_next got=%0h/%0h exp=55/1", wb_alu_result, wb_reg_write); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      clearIn();
      alu_result = 32'hCAFE; reg_dst = 2'b10; reg_write = 1'b1; mem_to_reg = 2'b10;
      @(posedge clk); #1;
      nCmp++; if (wb_reg_addr !== 5'd31 || wb_mem_to_reg !== 2'b10) begin nErr++; $display("FAIL rm_link got=%0d/%0h exp=31/2", wb_reg_addr, wb_mem_to_reg); end
      #2 rst = 1'b0;
      #1;
      nCmp++; if (wb_alu_result !== 32'h0 || wb_reg_write !== 1'b0) begin nErr++; $display("FAIL rm_wbclr got=%0h/%0h exp=0/0", wb_alu_result, wb_reg_write); end
      nCmp++; if (wb_reg_addr !== 5'd0 || wb_mem_to_reg !== 2'b00) begin nErr++; $display("FAIL rm_wbclr2 got=%0d/%0h exp=0/0", wb_reg_addr, wb_mem_to_reg); end
      @(negedge clk);
      rst = 1'b1;
      clearIn();
      mem_read = 1'b1; alu_result = 32'h200; reg_write = 1'b1;
      @(negedge clk);
      #1;
      nCmp++; if (stall !== 1'b1) begin nErr++; $display("FAIL rm_inwait got=%0h exp=1", stall); end
      #2 rst = 1'b0;
      #1;
      nCmp++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin nErr++; $display("FAIL rm_drop got=%0h%0h exp=00", dmem_req, stall); end
      nCmp++; if (dmem_addr !== 32'h0) begin nErr++; $display("FAIL rm_addr got=%0h exp=0", dmem_addr); end
      @(negedge clk);
      clearIn();
      dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
      rst = 1'b1;
      #1;
      nCmp++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin nErr++; $display("FAIL rm_idle got=%0h%0h exp=00", dmem_req, stall); end
      @(posedge clk); #1;
      nCmp++; if (wb_mem_data !== 32'h0 || wb_reg_write !== 1'b0) begin nErr++; $display("FAIL rm_lateack got=%0h/%0h exp=0/0", wb_mem_data, wb_reg_write); end
      @(negedge clk);
      clearIn();
      alu_result = 32'h99; reg_write = 1'b1;
      @(posedge clk); #1;
      nCmp++; if (wb_alu_result !== 32'h99 || wb_reg_write !== 1'b1) begin nErr++; $display("FAIL rm_after got=%0h/%0h exp=99/1", wb_alu_result, wb_reg_write); end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_dest();
      test_load_zero_wait();
      test_store_wait();
      test_misalign();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
